// File: rtl/fixed_to_bcd_formatter_if.sv
// Start/busy/done handshake and result bus between a Q16.16 producer and the
// BCD formatter; the formatter sits on the slave side.
interface fixed_to_bcd_formatter_if #(
    parameter int FRAC_DIGITS = 4
);
    logic                       start;
    logic [31:0]                data_in;
    logic                       busy;
    logic                       done;
    logic                       sign;
    logic [19:0]                int_bcd;
    logic [4*FRAC_DIGITS-1:0]   frac_bcd;

    modport master (
        output start, data_in,
        input  busy, done, sign, int_bcd, frac_bcd
    );

    modport slave (
        input  start, data_in,
        output busy, done, sign, int_bcd, frac_bcd
    );
endinterface

// File: rtl/fixed_to_bcd_formatter.sv
// Signed Q16.16 to sign + BCD digits: double-dabble on the integer part,
// then repeated multiply-by-10 (truncating) on the fraction, one step per clock.
module fixed_to_bcd_formatter #(
    parameter int FRAC_DIGITS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    fixed_to_bcd_formatter_if.slave     bus
);
    localparam int         FW        = 4 * FRAC_DIGITS;
    localparam logic [3:0] INT_LAST  = 4'd15;
    localparam logic [3:0] FRAC_LAST = 4'(FRAC_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        INT_CONV,
        FRAC_CONV
    } state_t;

    state_t         state;
    state_t         next_state;

    logic           sign_r;
    logic [15:0]    int_sh;
    logic [19:0]    bcd_acc;
    logic [15:0]    frac_acc;
    logic [FW-1:0]  frac_sh;
    logic [3:0]     cnt;

    logic           done_q;
    logic           sign_q;
    logic [19:0]    int_q;
    logic [FW-1:0]  frac_q;

    logic           busy_c;
    logic           load;
    logic           int_step;
    logic           frac_step;
    logic           finish;

    logic [31:0]    mag;
    logic [19:0]    bcd_adj;
    logic [19:0]    bcd_next;
    logic [19:0]    prod;
    logic [FW-1:0]  frac_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (bus.start)          next_state = INT_CONV;
            INT_CONV:  if (cnt == INT_LAST)    next_state = FRAC_CONV;
            FRAC_CONV: if (cnt == FRAC_LAST)   next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_c    = (state != IDLE);
        load      = (state == IDLE) && bus.start;
        int_step  = (state == INT_CONV);
        frac_step = (state == FRAC_CONV);
        finish    = frac_step && (cnt == FRAC_LAST);
    end

    // Magnitude is taken as 32-bit unsigned so that -32768.0 stays representable.
    always_comb begin
        mag = bus.data_in[31] ? (~bus.data_in + 32'd1) : bus.data_in;
    end

    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < 5; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = (bcd_adj << 1) | 20'(int_sh[15]);
    end

    // The top nibble of frac_acc*10 is the next decimal digit, always 0..9.
    always_comb begin
        prod      = {4'd0, frac_acc} * 20'd10;
        frac_next = (frac_sh << 4) | FW'(prod[19:16]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r   <= 1'b0;
            int_sh   <= '0;
            bcd_acc  <= '0;
            frac_acc <= '0;
            frac_sh  <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            int_q    <= '0;
            frac_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                sign_r   <= bus.data_in[31];
                int_sh   <= mag[31:16];
                bcd_acc  <= '0;
                frac_acc <= mag[15:0];
                frac_sh  <= '0;
                cnt      <= '0;
            end
            if (int_step) begin
                bcd_acc <= bcd_next;
                int_sh  <= int_sh << 1;
                cnt     <= (cnt == INT_LAST) ? 4'd0 : cnt + 4'd1;
            end
            if (frac_step) begin
                frac_acc <= prod[15:0];
                frac_sh  <= frac_next;
                cnt      <= cnt + 4'd1;
            end
            // Display-facing registers only move here, so a half-built value is never visible.
            if (finish) begin
                cnt    <= '0;
                done_q <= 1'b1;
                sign_q <= sign_r;
                int_q  <= bcd_acc;
                frac_q <= frac_next;
            end
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_q;
    assign bus.sign     = sign_q;
    assign bus.int_bcd  = int_q;
    assign bus.frac_bcd = frac_q;
endmodule

// File: tb/tb_fixed_to_bcd_formatter.sv
// Directed scoreboard bench for fixed_to_bcd_formatter (four- and two-digit
// fraction instances).
module tb_fixed_to_bcd_formatter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fixed_to_bcd_formatter_if #(.FRAC_DIGITS(4)) bus4();
    fixed_to_bcd_formatter_if #(.FRAC_DIGITS(2)) bus2();

    fixed_to_bcd_formatter #(.FRAC_DIGITS(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    fixed_to_bcd_formatter #(.FRAC_DIGITS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct packed {
        logic        sign;
        logic [19:0] int_bcd;
        logic [15:0] frac_bcd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edges;
    int   done_seen;

    function automatic exp_t mkExp(input logic s, input logic [19:0] i, input logic [15:0] f);
        exp_t e;
        e.sign     = s;
        e.int_bcd  = i;
        e.frac_bcd = f;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; launches one conversion and records what it must produce.
    task automatic applyStimulus(input logic [31:0] value, input exp_t exp);
        bus4.data_in = value;
        bus4.start   = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus4.start   = 1'b0;
        bus4.data_in = ~value;
        checkOutput("busy_after_start", 32'(bus4.busy), 32'd1);
        checkOutput("done_low_after_start", 32'(bus4.done), 32'd0);
    endtask

    task automatic waitDone(input int glitch_edge, input logic [31:0] glitch_value, output int n);
        n = 0;
        while (n < 100) begin
            if (n + 1 == glitch_edge) begin
                bus4.start   = 1'b1;
                bus4.data_in = glitch_value;
            end else begin
                bus4.start = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus4.done === 1'b1) break;
        end
        bus4.start = 1'b0;
    endtask

    task automatic checkResult(input string tag, input int n);
        exp_t e;
        checkOutput({tag, "_latency"}, 32'(n), 32'd20);
        checkOutput({tag, "_done"}, 32'(bus4.done), 32'd1);
        checkOutput({tag, "_busy"}, 32'(bus4.busy), 32'd0);
        checkOutput({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_sign"}, 32'(bus4.sign), 32'(e.sign));
            checkOutput({tag, "_int"}, 32'(bus4.int_bcd), 32'(e.int_bcd));
            checkOutput({tag, "_frac"}, 32'(bus4.frac_bcd), 32'(e.frac_bcd));
        end
    endtask

    task automatic checkDoneDropped(input string tag);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_width"}, 32'(bus4.done), 32'd0);
    endtask

    task automatic runOne(input string tag, input logic [31:0] value, input exp_t exp);
        int n;
        applyStimulus(value, exp);
        waitDone(0, 32'd0, n);
        checkResult(tag, n);
        checkDoneDropped(tag);
    endtask

    initial begin
        rst          = 1'b1;
        bus4.start   = 1'b0;
        bus4.data_in = 32'd0;
        bus2.start   = 1'b0;
        bus2.data_in = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus4.busy), 32'd0);
        checkOutput("reset_done", 32'(bus4.done), 32'd0);
        checkOutput("reset_sign", 32'(bus4.sign), 32'd0);
        checkOutput("reset_int", 32'(bus4.int_bcd), 32'd0);
        checkOutput("reset_frac", 32'(bus4.frac_bcd), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        runOne("zero",     32'h0000_0000, mkExp(1'b0, 20'h00000, 16'h0000));
        runOne("pos_1p5",  32'h0001_8000, mkExp(1'b0, 20'h00001, 16'h5000));
        runOne("neg_1p5",  32'hFFFE_8000, mkExp(1'b1, 20'h00001, 16'h5000));
        runOne("pi",       32'h0003_243F, mkExp(1'b0, 20'h00003, 16'h1415));
        runOne("max_pos",  32'h7FFF_FFFF, mkExp(1'b0, 20'h32767, 16'h9999));
        runOne("min_neg",  32'h8000_0000, mkExp(1'b1, 20'h32768, 16'h0000));
        runOne("neg_tiny", 32'hFFFF_FFFF, mkExp(1'b1, 20'h00000, 16'h0000));

        // A start pulse at edge 5 of a busy conversion must be dropped.
        applyStimulus(32'h0003_243F, mkExp(1'b0, 20'h00003, 16'h1415));
        waitDone(5, 32'h0001_8000, edges);
        checkResult("ignored_start", edges);

        // Back-to-back start issued in the done cycle.
        applyStimulus(32'h7FFF_FFFF, mkExp(1'b0, 20'h32767, 16'h9999));
        checkOutput("hold_int_mid_conv", 32'(bus4.int_bcd), 32'h00003);
        waitDone(0, 32'd0, edges);
        checkResult("back_to_back", edges);
        checkDoneDropped("back_to_back");

        // Reset at edge 10 aborts the conversion with no done pulse.
        applyStimulus(32'h0001_8000, mkExp(1'b0, 20'h00001, 16'h5000));
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("hold_frac_before_abort", 32'(bus4.frac_bcd), 32'h9999);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(bus4.busy), 32'd0);
        checkOutput("abort_done", 32'(bus4.done), 32'd0);
        checkOutput("abort_sign", 32'(bus4.sign), 32'd0);
        checkOutput("abort_int", 32'(bus4.int_bcd), 32'd0);
        checkOutput("abort_frac", 32'(bus4.frac_bcd), 32'd0);
        void'(sb.pop_front());
        done_seen = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (bus4.done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);
        checkOutput("abort_idle_busy", 32'(bus4.busy), 32'd0);
        runOne("after_abort", 32'hFFFE_8000, mkExp(1'b1, 20'h00001, 16'h5000));

        // Two-digit instance: shorter latency, narrower fraction.
        bus2.data_in = 32'h0001_8000;
        bus2.start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus2.start = 1'b0;
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus2.done === 1'b1) break;
        end
        checkOutput("fd2_latency", 32'(edges), 32'd18);
        checkOutput("fd2_done", 32'(bus2.done), 32'd1);
        checkOutput("fd2_sign", 32'(bus2.sign), 32'd0);
        checkOutput("fd2_int", 32'(bus2.int_bcd), 32'h00001);
        checkOutput("fd2_frac", 32'(bus2.frac_bcd), 32'h50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
